// File: rtl/ysyx_25030093_wbu_pkg.sv
// Shared types for the writeback unit: FSM encoding, result-buffer entry layout and default depth.
package ysyx_25030093_wbu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int CSR_AW    = 12;
  localparam int DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WRITE  = 2'b01,
    ST_COMMIT = 2'b10
  } wbu_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   rd_data;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_wen;
    logic [XLEN-1:0]   csr_wdata;
    logic [CSR_AW-1:0] csr_addr;
    logic              csr_wen;
    logic [XLEN-1:0]   dnpc;
  } wbu_entry_t;

  localparam int ENTRY_W = XLEN + REG_AW + 1 + XLEN + CSR_AW + 1 + XLEN;

endpackage

// File: rtl/ysyx_25030093_wbu_if.sv
// EXU-result intake, register-file/CSR write ports and IFU commit handshake of the writeback unit.
interface ysyx_25030093_wbu_if;
  import ysyx_25030093_wbu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   rd_data;
  logic [REG_AW-1:0] rd_addr;
  logic              rd_wen;
  logic [XLEN-1:0]   csr_wdata;
  logic [CSR_AW-1:0] csr_addr;
  logic              csr_wen;
  logic [XLEN-1:0]   dnpc;

  logic              gpr_wen;
  logic [REG_AW-1:0] gpr_waddr;
  logic [XLEN-1:0]   gpr_wdata;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata_o;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   retire_cnt;

  modport master (
    output in_valid, rd_data, rd_addr, rd_wen, csr_wdata, csr_addr, csr_wen, dnpc, out_ready,
    input  in_ready, gpr_wen, gpr_waddr, gpr_wdata, csr_we, csr_waddr, csr_wdata_o,
           out_valid, next_pc, retire_cnt
  );

  modport slave (
    input  in_valid, rd_data, rd_addr, rd_wen, csr_wdata, csr_addr, csr_wen, dnpc, out_ready,
    output in_ready, gpr_wen, gpr_waddr, gpr_wdata, csr_we, csr_waddr, csr_wdata_o,
           out_valid, next_pc, retire_cnt
  );

endinterface

// File: rtl/ysyx_25030093_wbu_fifo.sv
// Result buffer: DEPTH-entry ring with head/tail pointers and occupancy count; head is read combinationally.
module ysyx_25030093_wbu_fifo
  import ysyx_25030093_wbu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  wbu_entry_t push_entry,
  input  logic       pop,
  output wbu_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wbu_entry_t    mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW:0]   count;

  // Storage is not reset: nothing downstream looks at a slot until it has been pushed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[head_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/ysyx_25030093_wbu.sv
// Writeback unit: each buffered result spends one cycle on the GPR/CSR write ports, then waits in COMMIT for the IFU.
// One instruction per 3 cycles; in_ready comes from buffer occupancy only, so out_ready never reaches it combinationally.
module ysyx_25030093_wbu
  import ysyx_25030093_wbu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  ysyx_25030093_wbu_if.slave wb
);

  wbu_entry_t        push_entry;
  wbu_entry_t        head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              gpr_hit;

  wbu_state_t        state;
  logic              gpr_wen_q;
  logic [REG_AW-1:0] gpr_waddr_q;
  logic [XLEN-1:0]   gpr_wdata_q;
  logic              csr_we_q;
  logic [CSR_AW-1:0] csr_waddr_q;
  logic [XLEN-1:0]   csr_wdata_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   next_pc_q;
  logic [XLEN-1:0]   retire_cnt_q;

  assign push_entry = '{
    rd_data:   wb.rd_data,
    rd_addr:   wb.rd_addr,
    rd_wen:    wb.rd_wen,
    csr_wdata: wb.csr_wdata,
    csr_addr:  wb.csr_addr,
    csr_wen:   wb.csr_wen,
    dnpc:      wb.dnpc
  };

  assign push    = wb.in_valid && !full;
  assign pop     = (state == ST_COMMIT) && wb.out_ready;
  assign gpr_hit = head.rd_wen && (head.rd_addr != '0);

  ysyx_25030093_wbu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // Write ports are loaded on entry to WRITE and cleared on leaving it, so a COMMIT stall never repeats a write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      gpr_wen_q    <= 1'b0;
      gpr_waddr_q  <= '0;
      gpr_wdata_q  <= '0;
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= '0;
      csr_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      next_pc_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state       <= ST_WRITE;
            gpr_wen_q   <= gpr_hit;
            gpr_waddr_q <= gpr_hit ? head.rd_addr : '0;
            gpr_wdata_q <= gpr_hit ? head.rd_data : '0;
            csr_we_q    <= head.csr_wen;
            csr_waddr_q <= head.csr_wen ? head.csr_addr : '0;
            csr_wdata_q <= head.csr_wen ? head.csr_wdata : '0;
          end
        end
        ST_WRITE: begin
          state       <= ST_COMMIT;
          gpr_wen_q   <= 1'b0;
          gpr_waddr_q <= '0;
          gpr_wdata_q <= '0;
          csr_we_q    <= 1'b0;
          csr_waddr_q <= '0;
          csr_wdata_q <= '0;
          out_valid_q <= 1'b1;
          next_pc_q   <= head.dnpc;
        end
        ST_COMMIT: begin
          if (wb.out_ready) begin
            state        <= ST_IDLE;
            out_valid_q  <= 1'b0;
            next_pc_q    <= '0;
            retire_cnt_q <= retire_cnt_q + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wb.in_ready    = !full;
  assign wb.gpr_wen     = gpr_wen_q;
  assign wb.gpr_waddr   = gpr_waddr_q;
  assign wb.gpr_wdata   = gpr_wdata_q;
  assign wb.csr_we      = csr_we_q;
  assign wb.csr_waddr   = csr_waddr_q;
  assign wb.csr_wdata_o = csr_wdata_q;
  assign wb.out_valid   = out_valid_q;
  assign wb.next_pc     = next_pc_q;
  assign wb.retire_cnt  = retire_cnt_q;

endmodule

// File: doc/ysyx_25030093_wbu.md
# ysyx_25030093_wbu

Writeback unit: the consumer end of the EXU result handshake. It accepts EXU results (`in_valid`/`in_ready`) into a 2-entry buffer, drives the GPR and CSR write ports, and then presents each retired instruction's next PC to the IFU through a commit handshake (`out_valid`/`out_ready`). It sits between the EXU and the register file / IFU and also keeps a retired-instruction counter.

## Interface
- `DEPTH`, default 2: result buffer entries; must be a power of two, ≥ 2.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_valid` input 1: EXU result valid.
- `in_ready` output 1: WBU can accept a result.
- `rd_data` input 32: GPR write data.
- `rd_addr` input 5: GPR destination.
- `rd_wen` input 1: GPR write requested.
- `csr_wdata` input 32: CSR write data.
- `csr_addr` input 12: CSR destination.
- `csr_wen` input 1: CSR write requested.
- `dnpc` input 32: next PC of this instruction.
- `gpr_wen` output 1, `gpr_waddr` output 5, `gpr_wdata` output 32: register-file write port.
- `csr_we` output 1, `csr_waddr` output 12, `csr_wdata_o` output 32: CSR write port.
- `out_valid` output 1: commit valid to IFU.
- `out_ready` input 1: IFU accepts commit.
- `next_pc` output 32: committed `dnpc`.
- `retire_cnt` output 32: retired-instruction count.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge pushes {rd_data, rd_addr, rd_wen, csr_wdata, csr_addr, csr_wen, dnpc} at the tail.
- `in_ready = (count != DEPTH)`, decoded from registered count only; there is no combinational path from `out_ready`.
- FSM states are IDLE, WRITE, COMMIT.
  - IDLE: goes to WRITE when count ≠ 0; otherwise stays.
  - WRITE: held for exactly 1 cycle. `gpr_wen = head.rd_wen && head.rd_addr != 0`; `csr_we = head.csr_wen`. Address and data come from the head entry. Then goes to COMMIT.
  - COMMIT: `out_valid = 1`, `next_pc = head.dnpc`. On `out_ready`, pops the head, increments `retire_cnt` and returns to IDLE; otherwise holds.
- Write enables are asserted only in WRITE, so each entry writes exactly once, even if COMMIT stalls.
- A push and a pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
- A push while full cannot occur, because `in_ready` is 0.
- `retire_cnt` wraps from 0xFFFFFFFF to 0.
- Writes to x0 are suppressed, but the instruction still commits and counts.

## Timing
- Reset values:
  - outputs: `in_ready` = 1; `gpr_wen` = `csr_we` = `out_valid` = 0; `gpr_waddr` = `gpr_wdata` = `csr_waddr` = `csr_wdata_o` = `next_pc` = 0; `retire_cnt` = 0.
  - internal: state IDLE, count and pointers 0.
- Latency, with the push at edge E0 into an empty buffer:
  - E1: enter WRITE; write ports are active in the following cycle.
  - E2: register-file write lands; enter COMMIT.
  - E3 at earliest: commit handshake.
  - Sustained throughput is 1 instruction per 3 cycles.
- Data outputs are zero whenever their enable or valid is low. They never carry a stale head.
- Reset asserted mid-WRITE or mid-COMMIT drops all buffered entries. No write or commit for them ever appears, and outputs return to reset values immediately.
- `out_valid`, once high, stays high with a stable `next_pc` until `out_ready`.

## Structure
- Shared package `ysyx_25030093_wbu_pkg` holds:
  - the state encoding (IDLE = 2'b00, WRITE = 2'b01, COMMIT = 2'b10);
  - the entry field widths and the packed entry width (115 bits);
  - the DEPTH default.
- Sub-module `ysyx_25030093_wbu_fifo`: entry storage, head/tail pointers, count, `full`/`empty`.
- The top level holds the FSM, output decode and `retire_cnt`.

## Test plan
- **Single instruction.** Push rd_addr=5, rd_data=0x12345678, rd_wen=1, dnpc=0x80000004 with `out_ready` = 1. Required: `gpr_wen` high for exactly 1 cycle with those values, then `out_valid` with `next_pc` = 0x80000004, and `retire_cnt` = 1.
- **x0 suppression and CSR.** Push rd_addr=0, rd_wen=1, csr_wen=1, csr_addr=0x341, csr_wdata=0xDEADBEEF. Required: `gpr_wen` stays 0, `csr_we` pulses once with 0x341/0xDEADBEEF, and the instruction commits.
- **Backpressure.** Hold `out_ready` = 0 and push 3 results. Required: the first two are accepted and `in_ready` = 0 after the second; `gpr_wen` pulses once only; `out_valid`/`next_pc` stay stable. Releasing `out_ready` commits all three in order.
- **Simultaneous push and pop at count=1.** Required: count stays 1, `in_ready` stays 1, and order is preserved.
- **Reset mid-COMMIT.** Assert `reset` between edges. Required: `out_valid`, `gpr_wen` and `retire_cnt` go to 0 immediately, `in_ready` = 1, and no stale entry commits after release.
- **Counter wrap.** Force `retire_cnt` to 0xFFFFFFFF and commit one instruction. Required: `retire_cnt` = 0.
